// File: rtl/counting_signals_window.sv
// Windowed population counter: per-sample bit count summed over WINDOW samples.
// Results are held on a valid/ready port until the consumer takes them.
module counting_signals_window #(
    parameter int WIDTH  = 8,
    parameter int WINDOW = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              switch,
    input  logic                              mode,
    input  logic                              flush,
    input  logic                              in_valid,
    input  logic [WIDTH-1:0]                  in_data,
    output logic                              in_ready,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [$clog2(WIDTH*WINDOW+1)-1:0] out_count,
    output logic [$clog2(WINDOW+1)-1:0]       out_samples,
    output logic [$clog2(WIDTH+1)-1:0]        last_pop
);

    localparam int POP_W = $clog2(WIDTH + 1);
    localparam int SUM_W = $clog2(WIDTH * WINDOW + 1);
    localparam int NS_W  = $clog2(WINDOW + 1);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t             state_q, state_n;
    logic [SUM_W-1:0]   sum_q, sum_n;
    logic [NS_W-1:0]    nsamp_q, nsamp_n;
    logic [POP_W-1:0]   last_pop_q, last_pop_n;
    logic [SUM_W-1:0]   out_count_q, out_count_n;
    logic [NS_W-1:0]    out_samples_q, out_samples_n;

    logic [POP_W-1:0]   pop;
    logic [SUM_W-1:0]   sum_inc;
    logic [NS_W-1:0]    nsamp_inc;
    logic               acc;
    logic               win_full;

    assign in_ready    = switch && (state_q == ACCUM) && !rst;
    assign acc         = in_valid && in_ready;
    assign out_valid   = (state_q == HOLD);
    assign out_count   = out_count_q;
    assign out_samples = out_samples_q;
    assign last_pop    = last_pop_q;

    assign sum_inc   = sum_q + SUM_W'(pop);
    assign nsamp_inc = nsamp_q + NS_W'(1);
    assign win_full  = (nsamp_inc == NS_W'(WINDOW));

    // Count ones, or zeros when mode is set, by inverting each bit.
    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + POP_W'(in_data[i] ^ mode);
        end
    end

    // Next-state: accumulate, close a window on fill or flush, drain on handshake.
    always_comb begin
        state_n       = state_q;
        sum_n         = sum_q;
        nsamp_n       = nsamp_q;
        last_pop_n    = last_pop_q;
        out_count_n   = out_count_q;
        out_samples_n = out_samples_q;
        unique case (state_q)
            ACCUM: begin
                if (acc) begin
                    last_pop_n = pop;
                    if (win_full || flush) begin
                        out_count_n   = sum_inc;
                        out_samples_n = nsamp_inc;
                        sum_n         = '0;
                        nsamp_n       = '0;
                        state_n       = HOLD;
                    end else begin
                        sum_n   = sum_inc;
                        nsamp_n = nsamp_inc;
                    end
                end else if (flush && (nsamp_q != '0)) begin
                    out_count_n   = sum_q;
                    out_samples_n = nsamp_q;
                    sum_n         = '0;
                    nsamp_n       = '0;
                    state_n       = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_n = ACCUM;
                end
            end
        endcase
    end

    // State registers; reset discards any partial window or held result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ACCUM;
            sum_q         <= '0;
            nsamp_q       <= '0;
            last_pop_q    <= '0;
            out_count_q   <= '0;
            out_samples_q <= '0;
        end else begin
            state_q       <= state_n;
            sum_q         <= sum_n;
            nsamp_q       <= nsamp_n;
            last_pop_q    <= last_pop_n;
            out_count_q   <= out_count_n;
            out_samples_q <= out_samples_n;
        end
    end

endmodule
